strobed_reg_writer: RTL and testbench



---
 rtl/strobed_reg_pkg.sv | 23 ++
 rtl/strobed_reg_writer_queue.sv | 64 ++++++
 rtl/strobed_reg_writer.sv | 152 +++++++++++++++
 tb/tb_strobed_reg_writer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strobed_reg_pkg.sv
// Shared types and widths for the strobed register writer.
//   state_t      : writer FSM states
//   SENT_W       : width of the acknowledged-word counter
//   RETRY_W      : width of the saturating retry counter
//   timer_width(): ack-timeout timer width for a given ACK_TIMEOUT
package strobed_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam int SENT_W  = 16;
  localparam int RETRY_W = 8;

  function automatic int timer_width(input int ack_timeout);
    return (ack_timeout > 1) ? $clog2(ack_timeout) : 1;
  endfunction

endpackage

// File: rtl/strobed_reg_writer_queue.sv
// wclk_word_queue: single-clock FIFO holding words waiting to be strobed.
//   clk      : clock
//   rst_i    : synchronous active-high reset (flushes pointers and count)
//   push_i   : write data_i at the tail (caller guarantees not full)
//   pop_i    : drop the head word (caller guarantees not empty)
//   data_i   : word to enqueue
//   head_o   : word at the head of the queue
//   count_o  : occupancy, 0..DEPTH
module wclk_word_queue #(
  parameter int DSIZE = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DSIZE-1:0]         data_i,
  output logic [DSIZE-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/strobed_reg_writer.sv
// strobed_reg_writer: write-side driver for the strobed register synchronizer.
// Queues upstream words and issues each as a one-cycle winc/wdata strobe,
// waiting for the wfull round trip (rise then fall) before the next word.
// Unacknowledged strobes are re-issued after ACK_TIMEOUT cycles.
//   wclk, wrst_i          : clock, synchronous active-high reset
//   s_valid_i/s_data_i    : upstream word; s_ready_o = queue not full
//   winc_o/wdata_o        : strobe and word to the synchronizer
//   wfull_i               : synchronizer busy flag
//   busy_o                : FSM active or words queued
//   count_o               : queue occupancy
//   sent_o / retry_o      : acknowledged words (wraps) / retries (saturates)
//
// state        | meaning
// ST_IDLE      | waiting for a queued word and wfull_i low
// ST_ISSUE     | winc_o high for this one cycle
// ST_WAIT_ACK  | waiting for wfull_i to rise; times out into a re-issue
// ST_WAIT_DONE | waiting for wfull_i to fall; counts the word as sent
// ST_HOLDOFF   | idle gap before the next word may be issued
module strobed_reg_writer
  import strobed_reg_pkg::*;
#(
  parameter int DSIZE       = 16,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 32,
  parameter int HOLDOFF     = 2
) (
  input  logic                    wclk,
  input  logic                    wrst_i,
  input  logic                    s_valid_i,
  input  logic [DSIZE-1:0]        s_data_i,
  output logic                    s_ready_o,
  output logic                    winc_o,
  output logic [DSIZE-1:0]        wdata_o,
  input  logic                    wfull_i,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [SENT_W-1:0]       sent_o,
  output logic [RETRY_W-1:0]      retry_o
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int TIMER_W = timer_width(ACK_TIMEOUT);
  localparam int HOLD_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [DSIZE-1:0]     wdata_q, wdata_d;
  logic                 winc_q, winc_d;
  logic [SENT_W-1:0]    sent_q, sent_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;

  logic                 push, pop;
  logic [DSIZE-1:0]     head;
  logic [CNT_W-1:0]     count;

  assign s_ready_o = (count < CNT_W'(DEPTH));
  assign push      = s_valid_i && s_ready_o;

  wclk_word_queue #(
    .DSIZE (DSIZE),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (wclk),
    .rst_i   (wrst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (s_data_i),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    wdata_d = wdata_q;
    sent_d  = sent_q;
    retry_d = retry_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A high wfull_i here means the synchronizer still owns a word.
        if ((count != '0) && !wfull_i) begin
          state_d = ST_ISSUE;
          wdata_d = head;
          pop     = 1'b1;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (wfull_i) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
          state_d = ST_ISSUE;
          if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!wfull_i) begin
          sent_d = sent_q + SENT_W'(1);
          if (HOLDOFF == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            hold_d  = HOLD_W'(HOLDOFF);
          end
        end
      end
      ST_HOLDOFF: begin
        if (hold_q == '0) state_d = ST_IDLE;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered decode so winc_o is glitch-free and aligned with ISSUE.
    winc_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge wclk) begin
    if (wrst_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      hold_q  <= '0;
      wdata_q <= '0;
      winc_q  <= 1'b0;
      sent_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      wdata_q <= wdata_d;
      winc_q  <= winc_d;
      sent_q  <= sent_d;
      retry_q <= retry_d;
    end
  end

  assign winc_o  = winc_q;
  assign wdata_o = wdata_q;
  assign busy_o  = (state_q != ST_IDLE) || (count != '0);
  assign count_o = count;
  assign sent_o  = sent_q;
  assign retry_o = retry_q;

endmodule

// File: tb/tb_strobed_reg_writer.sv
module tb_strobed_reg_writer;

  localparam int DSIZE       = 16;
  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 32;
  localparam int HOLDOFF     = 2;

  logic              wclk = 1'b0;
  logic              wrst_i;
  logic              s_valid_i;
  logic [DSIZE-1:0]  s_data_i;
  logic              s_ready_o;
  logic              winc_o;
  logic [DSIZE-1:0]  wdata_o;
  logic              wfull_i;
  logic              busy_o;
  logic [2:0]        count_o;
  logic [15:0]       sent_o;
  logic [7:0]        retry_o;

  logic tb_full   = 1'b0;
  logic resp_full = 1'b0;
  assign wfull_i = tb_full | resp_full;

  strobed_reg_writer #(
    .DSIZE(DSIZE), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .HOLDOFF(HOLDOFF)
  ) dut (
    .wclk(wclk), .wrst_i(wrst_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(s_ready_o), .winc_o(winc_o), .wdata_o(wdata_o), .wfull_i(wfull_i),
    .busy_o(busy_o), .count_o(count_o), .sent_o(sent_o), .retry_o(retry_o)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge wclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe log: data and the edge index that started the strobe cycle.
  logic [DSIZE-1:0] str_data[$];
  int               str_cyc[$];
  logic             prev_winc = 1'b0;

  always @(negedge wclk) begin
    if (winc_o) begin
      chk("winc_single_cycle", {31'b0, prev_winc}, 32'd0);
      str_data.push_back(wdata_o);
      str_cyc.push_back(cyc);
    end
    prev_winc = winc_o;
  end

  // Synchronizer stand-in: answers each strobe with a random-delay full pulse.
  bit auto_ack = 1'b0;
  int resp_d, resp_l;
  always begin
    @(negedge wclk);
    if (auto_ack && winc_o) begin
      resp_d = $urandom_range(10, 1);
      resp_l = $urandom_range(8, 1);
      repeat (resp_d) @(posedge wclk);
      #1 resp_full = 1'b1;
      repeat (resp_l) @(posedge wclk);
      #1 resp_full = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_i = 1'b1;
    step(1);
    wrst_i = 1'b0;
    str_data.delete();
    str_cyc.delete();
  endtask

  task automatic push_word(input logic [DSIZE-1:0] d, output bit stalled);
    bit rdy;
    int n = 0;
    stalled   = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    do begin
      rdy = s_ready_o;
      step(1);
      n++;
      if (!rdy) stalled = 1'b1;
    end while (!rdy && n < 300);
    chk("push_accepted", {31'b0, rdy}, 32'd1);
    s_valid_i = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (str_data.size() < n && k < budget) begin
      step(1);
      k++;
    end
    chk("strobes_seen", {31'b0, (str_data.size() >= n)}, 32'd1);
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k = 0;
    while (sent_o != n[15:0] && k < budget) begin
      step(1);
      k++;
    end
    chk("sent_reached", {16'b0, sent_o}, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit              st, stall_seen;
    int              k, f;
    logic [DSIZE-1:0] w;
    logic [DSIZE-1:0] exp_q[$];

    wrst_i    = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    step(2);
    do_reset();

    // Reset state
    chk("rst_count", {29'b0, count_o}, 0);
    chk("rst_ready", {31'b0, s_ready_o}, 1);
    chk("rst_winc",  {31'b0, winc_o}, 0);
    chk("rst_wdata", {16'b0, wdata_o}, 0);
    chk("rst_busy",  {31'b0, busy_o}, 0);
    chk("rst_sent",  {16'b0, sent_o}, 0);
    chk("rst_retry", {24'b0, retry_o}, 0);

    // Single word: strobe in the cycle after push edge + 1
    push_word(16'hA5A5, st);
    k = cyc;
    chk("t1_count_after_push", {29'b0, count_o}, 1);
    step(1);
    chk("t1_winc_high", {31'b0, winc_o}, 1);
    chk("t1_wdata", {16'b0, wdata_o}, 32'hA5A5);
    step(1);
    chk("t1_winc_low", {31'b0, winc_o}, 0);
    chk("t1_strobe_count", str_data.size(), 1);
    chk("t1_strobe_cycle", str_cyc[0], k + 1);
    step(4);
    tb_full = 1'b1;
    step(20);
    tb_full = 1'b0;
    step(1);
    chk("t1_sent", {16'b0, sent_o}, 1);
    chk("t1_retry", {24'b0, retry_o}, 0);
    for (int i = 0; i <= HOLDOFF; i++) begin
      step(1);
      chk("t1_busy_holdoff", {31'b0, busy_o}, (i < HOLDOFF) ? 1 : 0);
    end
    chk("t1_strobe_total", str_data.size(), 1);

    // Burst of six through a four-deep queue
    do_reset();
    auto_ack   = 1'b1;
    stall_seen = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      push_word(i[DSIZE-1:0], st);
      stall_seen |= st;
    end
    chk("t2_upstream_stalled", {31'b0, stall_seen}, 1);
    wait_sent(6, 1000);
    chk("t2_strobe_count", str_data.size(), 6);
    for (int i = 0; i < 6 && i < str_data.size(); i++)
      chk("t2_order", {16'b0, str_data[i]}, i + 1);
    chk("t2_retry", {24'b0, retry_o}, 0);
    step(HOLDOFF + 2);
    chk("t2_idle_busy", {31'b0, busy_o}, 0);
    auto_ack = 1'b0;

    // Lost strobe: re-issue every ACK_TIMEOUT+1 cycles
    do_reset();
    w = DSIZE'($urandom);
    push_word(w, st);
    wait_strobes(4, 4 * (ACK_TIMEOUT + 1) + 20);
    chk("t3_retry3", {24'b0, retry_o}, 3);
    for (int i = 0; i < 3 && i + 1 < str_cyc.size(); i++) begin
      chk("t3_period", str_cyc[i+1] - str_cyc[i], ACK_TIMEOUT + 1);
      chk("t3_same_data", {16'b0, str_data[i+1]}, {16'b0, w});
    end
    tb_full = 1'b1;
    step(3);
    tb_full = 1'b0;
    step(2);
    chk("t3_sent", {16'b0, sent_o}, 1);
    chk("t3_retry_hold", {24'b0, retry_o}, 3);
    step(HOLDOFF + 2);

    // Preexisting full holds off issue
    do_reset();
    tb_full = 1'b1;
    push_word(16'hBEEF, st);
    step(10);
    chk("t4_no_strobe", str_data.size(), 0);
    chk("t4_busy", {31'b0, busy_o}, 1);
    chk("t4_count", {29'b0, count_o}, 1);
    tb_full = 1'b0;
    f = cyc;
    step(3);
    chk("t4_strobe_count", str_data.size(), 1);
    if (str_data.size() >= 1) begin
      chk("t4_strobe_cycle", str_cyc[0], f + 1);
      chk("t4_data", {16'b0, str_data[0]}, 32'hBEEF);
    end
    tb_full = 1'b1;
    step(2);
    tb_full = 1'b0;
    wait_sent(1, 20);

    // Reset during WAIT_ACK with three words queued
    do_reset();
    for (int i = 0; i < 4; i++) push_word(DSIZE'($urandom), st);
    chk("t5_count_before", {29'b0, count_o}, 3);
    chk("t5_one_strobe", str_data.size(), 1);
    chk("t5_busy_before", {31'b0, busy_o}, 1);
    do_reset();
    chk("t5_count", {29'b0, count_o}, 0);
    chk("t5_winc", {31'b0, winc_o}, 0);
    chk("t5_wdata", {16'b0, wdata_o}, 0);
    chk("t5_sent", {16'b0, sent_o}, 0);
    chk("t5_retry", {24'b0, retry_o}, 0);
    step(100);
    chk("t5_no_strobe", str_data.size(), 0);
    chk("t5_busy_after", {31'b0, busy_o}, 0);

    // Retry counter saturation
    do_reset();
    push_word(DSIZE'($urandom), st);
    wait_strobes(301, 301 * (ACK_TIMEOUT + 1) + 50);
    chk("t6_retry_sat", {24'b0, retry_o}, 255);
    step(ACK_TIMEOUT + 2);
    chk("t6_retry_still_sat", {24'b0, retry_o}, 255);
    tb_full = 1'b1;
    step(3);
    tb_full = 1'b0;
    wait_sent(1, 20);
    step(HOLDOFF + 2);

    // Random words with random gaps against a FIFO reference
    do_reset();
    auto_ack = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      w = DSIZE'($urandom);
      push_word(w, st);
      exp_q.push_back(w);
      step($urandom_range(3, 0));
    end
    wait_sent(40, 3000);
    chk("t7_strobe_count", str_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < str_data.size(); i++)
      chk("t7_data", {16'b0, str_data[i]}, {16'b0, exp_q[i]});
    chk("t7_retry", {24'b0, retry_o}, 0);
    step(HOLDOFF + 2);
    chk("t7_count", {29'b0, count_o}, 0);
    chk("t7_busy", {31'b0, busy_o}, 0);
    auto_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
